tohost_uart: RTL
================

TOHOST_UART -- requirements
Module: tohost_uart

Interface
REQ-001 Parameter TOHOST_ADDR, default 32'h4000_0000, data-memory address of the host-interface register.
REQ-002 Parameter FIFO_DEPTH, default 16, character FIFO entries; power of two, 2..256.
REQ-003 Parameter CLKS_PER_BIT, default 16, aclk_i cycles per UART bit; minimum 2.
REQ-004 aclk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 areset_i  in  1  reset, synchronous, active-high.
REQ-006 dmem_wvalid_i  in  1  core data-memory write strobe, one cycle per write.
REQ-007 dmem_waddr_i  in  32  write byte address.
REQ-008 dmem_wdata_i  in  32  write data; [17:16] command, [15:0] payload.
REQ-009 stall_o  out  1  core must hold the current write; combinational.
REQ-010 uart_tx_o  out  1  serial output, 8N1, idle high, registered.
REQ-011 finish_o  out  1  sticky run-complete flag, registered.
REQ-012 exit_code_o  out  16  payload of the finish command, registered.
REQ-013 busy_o  out  1  high while the FIFO is non-empty or the transmitter is not IDLE.

Function
REQ-014 Host write: dmem_wvalid_i=1 and dmem_waddr_i==TOHOST_ADDR; all other writes ignored.
REQ-015 Command 2'b01 (char): push dmem_wdata_i[7:0] into the FIFO.
REQ-016 Command 2'b10 (finish): set finish_pend and latch exit_code_o<=dmem_wdata_i[15:0].
REQ-017 Commands 2'b00 and 2'b11: ignored, no state change.
REQ-018 stall_o=1 iff a char host write is present and the FIFO is full; that write is not accepted and is retried while held.
REQ-019 Finish writes never stall.
REQ-020 Host writes arriving while finish_pend=1 are ignored and never stall; exit_code_o holds the first finish payload.
REQ-021 FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; wrap is modulo 2*FIFO_DEPTH.
REQ-022 Full when the pointers differ only in the MSB; empty when equal.
REQ-023 Push and pop in the same cycle are both performed; count is unchanged.
REQ-024 When full, a pop in a cycle does not release the stall in that same cycle; stall_o is derived from the count at the start of the cycle.
REQ-025 Transmitter states: IDLE, START, DATA, STOP.
REQ-026 IDLE with FIFO non-empty: pop the head into an 8-bit shifter, go to START, drive uart_tx_o=0 from the next edge.
REQ-027 START lasts CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-028 DATA sends 8 bits LSB first, CLKS_PER_BIT cycles each, then go to STOP.
REQ-029 STOP drives 1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-030 A frame occupies exactly 10*CLKS_PER_BIT cycles.
REQ-031 From STOP with the FIFO non-empty, go through IDLE for exactly one cycle, so the inter-frame gap is 0 bit periods plus 1 clock.
REQ-032 Char accepted at edge k into an empty FIFO with the transmitter IDLE: uart_tx_o falls at edge k+2.
REQ-033 The bit counter is a down-counter reloaded to CLKS_PER_BIT-1 at each bit start; the bit advances when the counter reaches 0.
REQ-034 finish_o rises on the edge after a cycle in which finish_pend=1, the FIFO is empty and the transmitter is IDLE.
REQ-035 Every character accepted before the finish command is therefore fully serialized before finish_o rises.
REQ-036 finish_o stays 1 until reset.

Reset
REQ-037 When areset_i=1 at an edge: FIFO emptied, transmitter to IDLE, finish_pend=0.
REQ-038 Reset outputs: uart_tx_o=1, finish_o=0, exit_code_o=0, busy_o=0.
REQ-039 During reset, stall_o=0 and all host writes are ignored.
REQ-040 Reset mid-frame aborts the frame immediately; uart_tx_o returns high on that edge, with no partial stop bit.

Verification
REQ-041 Single char 0x41 (CLKS_PER_BIT=4) -> uart_tx_o low at k+2, bits 1,0,0,0,0,0,1,0 at 4 cycles each, high after 40 cycles; busy_o=0 on return to IDLE.
REQ-042 Burst of 20 chars 0x00..0x13 at one per cycle, FIFO_DEPTH=16 -> stall_o asserts on the 18th write (16 queued plus 1 popped); no loss; all 20 serialized in order.
REQ-043 Chars 'O','K' then finish with payload 0x0000 -> finish_o rises only after the second stop bit completes; exit_code_o=0x0000.
REQ-044 Finish with payload 0x0003, then char and finish with 0x0007 -> later writes ignored; exit_code_o=0x0003; no stall.
REQ-045 Write to TOHOST_ADDR+4, and command 2'b11 to TOHOST_ADDR -> no FIFO push, no finish, uart_tx_o stays 1.
REQ-046 areset_i pulsed during DATA bit 3 with 5 chars queued -> uart_tx_o=1 and busy_o=0 after that edge; a new char after reset transmits normally.

Source files
------------

// File: rtl/tohost_uart.sv
// Host-interface sink: a core writes characters into a FIFO that drains through an
// 8N1 UART transmitter, and a finish command raises a sticky flag once output has drained.
module tohost_uart #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h4000_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        aclk_i,
    input  logic        areset_i,
    input  logic        dmem_wvalid_i,
    input  logic [31:0] dmem_waddr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        stall_o,
    output logic        uart_tx_o,
    output logic        finish_o,
    output logic [15:0] exit_code_o,
    output logic        busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;

    tx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        finish_pend_q, finish_pend_d;
    logic        finish_q, finish_d;
    logic [15:0] exit_q, exit_d;

    logic [1:0]  cmd;
    logic        host_wr, char_wr, fin_wr;
    logic        fifo_empty, fifo_full, push, pop;
    logic        unused_wdata;

    assign cmd          = dmem_wdata_i[17:16];
    assign unused_wdata = ^dmem_wdata_i[31:18];

    // Once a finish is pending, or while in reset, the host port goes deaf.
    assign host_wr = dmem_wvalid_i && (dmem_waddr_i == TOHOST_ADDR) && !areset_i && !finish_pend_q;
    assign char_wr = host_wr && (cmd == 2'b01);
    assign fin_wr  = host_wr && (cmd == 2'b10);

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // Full is judged on start-of-cycle occupancy, so a same-cycle pop does not unstall.
    assign stall_o = char_wr && fifo_full;
    assign push    = char_wr && !fifo_full;
    assign pop     = (state_q == IDLE) && !fifo_empty && !areset_i;

    assign wptr_d = wptr_q + {{AW{1'b0}}, push};
    assign rptr_d = rptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge aclk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= dmem_wdata_i[7:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        tx_d          = 1'b1;
        finish_pend_d = finish_pend_q || fin_wr;
        exit_d        = fin_wr ? dmem_wdata_i[15:0] : exit_q;
        finish_d      = finish_q || (finish_pend_q && fifo_empty && (state_q == IDLE));

        // The line register follows the state one cycle late, giving the k+2 start edge.
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = START;
                    cnt_d   = CNT_MAX;
                    shift_d = mem_q[rptr_q[AW-1:0]];
                end
            end
            START: begin
                tx_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CNT_MAX;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (cnt_q == '0) begin
                    cnt_d   = CNT_MAX;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            tx_q          <= 1'b1;
            finish_pend_q <= 1'b0;
            finish_q      <= 1'b0;
            exit_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            tx_q          <= tx_d;
            finish_pend_q <= finish_pend_d;
            finish_q      <= finish_d;
            exit_q        <= exit_d;
        end
        bit_q   <= bit_d;
        shift_q <= shift_d;
    end

    assign uart_tx_o   = tx_q;
    assign finish_o    = finish_q;
    assign exit_code_o = exit_q;
    assign busy_o      = !fifo_empty || (state_q != IDLE);

endmodule
